// File: rtl/forward_hazard_ctrl_pkg.sv
// Shared pipeline definitions: forwarding select encodings and the
// per-stage tracking record used by the hazard controller and EXE stage.
package forward_hazard_ctrl_pkg;

  // Operand source selects for the instruction sitting in EXE.
  localparam logic [1:0] SEL_RF  = 2'b00;  // register file read value
  localparam logic [1:0] SEL_MEM = 2'b01;  // ALU result now in MEM
  localparam logic [1:0] SEL_WB  = 2'b10;  // value now being written back

  // One tracking slot per downstream stage.
  typedef struct packed {
    logic       valid;
    logic [3:0] dest;
    logic       wb_en;
    logic       mem_r_en;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  // A slot only produces a value if it holds a real, writing instruction.
  function automatic logic is_producer(input slot_t s);
    return s.valid & s.wb_en;
  endfunction

endpackage

// File: rtl/forward_hazard_ctrl_match.sv
// Compares one tracking slot against the two source registers of the
// instruction in ID. src2 only counts when it is actually read.
module hazard_match
  import forward_hazard_ctrl_pkg::*;
(
  input  slot_t      slot,
  input  logic [3:0] src1,
  input  logic [3:0] src2,
  input  logic       src2_valid,
  output logic       match1,
  output logic       match2
);

  // The load flag does not take part in the compare; the caller decides
  // what a load match means.
  logic unused_mem_r_en;
  assign unused_mem_r_en = slot.mem_r_en;

  // Producer/destination compare for each source operand.
  always_comb begin
    match1 = is_producer(slot) && (slot.dest == src1);
    match2 = is_producer(slot) && src2_valid && (slot.dest == src2);
  end

endmodule

// File: rtl/forward_hazard_ctrl.sv
// RAW hazard detection and forwarding-select generation for a 5-stage
// pipeline. Tracks what sits in EXE, MEM and WB and decides whether the
// ID instruction must stall or which bypass each operand should take.
module forward_hazard_ctrl
  import forward_hazard_ctrl_pkg::*;
#(
  parameter int FORWARD_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [3:0]  id_src1,
  input  logic [3:0]  id_src2,
  input  logic        id_src2_valid,
  input  logic [3:0]  id_dest,
  input  logic        id_wb_en,
  input  logic        id_mem_r_en,
  input  logic        branch_taken,
  output logic        stall,
  output logic [1:0]  sel_src1,
  output logic [1:0]  sel_src2,
  output logic [15:0] stall_count
);

  slot_t       exe_q, exe_d;
  slot_t       mem_q, mem_d;
  slot_t       wb_q,  wb_d;
  logic [1:0]  sel_src1_q, sel_src1_d;
  logic [1:0]  sel_src2_q, sel_src2_d;
  logic [15:0] stall_count_q, stall_count_d;

  logic exe_m1, exe_m2, mem_m1, mem_m2, wb_m1, wb_m2;
  logic accept;

  hazard_match u_exe_match (
    .slot(exe_q), .src1(id_src1), .src2(id_src2), .src2_valid(id_src2_valid),
    .match1(exe_m1), .match2(exe_m2)
  );

  hazard_match u_mem_match (
    .slot(mem_q), .src1(id_src1), .src2(id_src2), .src2_valid(id_src2_valid),
    .match1(mem_m1), .match2(mem_m2)
  );

  hazard_match u_wb_match (
    .slot(wb_q), .src1(id_src1), .src2(id_src2), .src2_valid(id_src2_valid),
    .match1(wb_m1), .match2(wb_m2)
  );

  // A WB match is never a hazard: the register file writes before ID reads.
  logic unused_wb_match;
  assign unused_wb_match = wb_m1 | wb_m2;

  // Stall decision from slot state and ID inputs only; a redirect wins.
  always_comb begin
    stall = 1'b0;
    if (id_valid && !branch_taken) begin
      if (FORWARD_EN != 0) begin
        stall = (exe_m1 | exe_m2) & exe_q.mem_r_en;
      end else begin
        stall = exe_m1 | exe_m2 | mem_m1 | mem_m2;
      end
    end
    accept = id_valid && !stall && !branch_taken;
  end

  // Next slot contents, forwarding selects and stall counter.
  always_comb begin
    exe_d         = SLOT_BUBBLE;
    mem_d         = exe_q;
    wb_d          = mem_q;
    sel_src1_d    = SEL_RF;
    sel_src2_d    = SEL_RF;
    stall_count_d = stall_count_q;
    if (accept) begin
      exe_d.valid    = 1'b1;
      exe_d.dest     = id_dest;
      exe_d.wb_en    = id_wb_en;
      exe_d.mem_r_en = id_mem_r_en;
      if (FORWARD_EN != 0) begin
        // Newer producer (EXE) takes priority over the older one (MEM).
        if (exe_m1)      sel_src1_d = SEL_MEM;
        else if (mem_m1) sel_src1_d = SEL_WB;
        if (exe_m2)      sel_src2_d = SEL_MEM;
        else if (mem_m2) sel_src2_d = SEL_WB;
      end
    end
    if (stall && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_q         <= SLOT_BUBBLE;
      mem_q         <= SLOT_BUBBLE;
      wb_q          <= SLOT_BUBBLE;
      sel_src1_q    <= SEL_RF;
      sel_src2_q    <= SEL_RF;
      stall_count_q <= 16'd0;
    end else begin
      exe_q         <= exe_d;
      mem_q         <= mem_d;
      wb_q          <= wb_d;
      sel_src1_q    <= sel_src1_d;
      sel_src2_q    <= sel_src2_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign sel_src1    = sel_src1_q;
  assign sel_src2    = sel_src2_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
// Directed bench for forward_hazard_ctrl. Two instances share the ID-side
// inputs: u_fwd with forwarding, u_nf stalling on every RAW hazard.
module tb_forward_hazard_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        id_valid, id_src2_valid, id_wb_en, id_mem_r_en, branch_taken;
  logic [3:0]  id_src1, id_src2, id_dest;
  logic        stall_f, stall_n;
  logic [1:0]  sel1_f, sel2_f, sel1_n, sel2_n;
  logic [15:0] cnt_f, cnt_n;

  int n_cmp = 0;
  int n_bad = 0;

  forward_hazard_ctrl #(.FORWARD_EN(1)) u_fwd (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1),
    .id_src2(id_src2), .id_src2_valid(id_src2_valid), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .branch_taken(branch_taken), .stall(stall_f), .sel_src1(sel1_f),
    .sel_src2(sel2_f), .stall_count(cnt_f)
  );

  forward_hazard_ctrl #(.FORWARD_EN(0)) u_nf (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1),
    .id_src2(id_src2), .id_src2_valid(id_src2_valid), .id_dest(id_dest),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .branch_taken(branch_taken), .stall(stall_n), .sel_src1(sel1_n),
    .sel_src2(sel2_n), .stall_count(cnt_n)
  );

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [15:0] got,
                           input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clk_edge();
    @(posedge clk); #1;
  endtask

  task automatic to_negedge();
    @(negedge clk); #1;
  endtask

  task automatic id_instr(input logic [3:0] s1, input logic [3:0] s2,
                          input logic s2v, input logic [3:0] d,
                          input logic wb, input logic ld);
    id_valid      = 1'b1;
    id_src1       = s1;
    id_src2       = s2;
    id_src2_valid = s2v;
    id_dest       = d;
    id_wb_en      = wb;
    id_mem_r_en   = ld;
    branch_taken  = 1'b0;
  endtask

  task automatic id_nop();
    id_valid      = 1'b0;
    id_src1       = 4'd0;
    id_src2       = 4'd0;
    id_src2_valid = 1'b0;
    id_dest       = 4'd0;
    id_wb_en      = 1'b0;
    id_mem_r_en   = 1'b0;
    branch_taken  = 1'b0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b0;
    id_nop();
    @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  // Bound on total run time.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    id_nop();
    #2 rst = 1'b0;
    #1;
    check_val("rst_stall", stall_f, 16'd0);
    check_val("rst_sel1", sel1_f, 16'd0);
    check_val("rst_sel2", sel2_f, 16'd0);
    check_val("rst_cnt", cnt_f, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;

    // ALU back-to-back: ADD R1,R2,R3 ; SUB R2,R1,R3
    id_instr(4'd2, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0);
    #1 check_val("b2b_add_stall", stall_f, 16'd0);
    clk_edge(); to_negedge();
    id_instr(4'd1, 4'd3, 1'b1, 4'd2, 1'b1, 1'b0);
    #1 check_val("b2b_sub_stall", stall_f, 16'd0);
    clk_edge();
    check_val("b2b_sel1", sel1_f, 16'd1);
    check_val("b2b_sel2", sel2_f, 16'd0);
    to_negedge();

    // Distance two: ADD R4 ; NOP ; ORR R5,R6,R4
    id_instr(4'd2, 4'd3, 1'b1, 4'd4, 1'b1, 1'b0);
    clk_edge(); to_negedge();
    id_nop();
    clk_edge(); to_negedge();
    id_instr(4'd6, 4'd4, 1'b1, 4'd5, 1'b1, 1'b0);
    #1 check_val("d2_stall", stall_f, 16'd0);
    clk_edge();
    check_val("d2_sel1", sel1_f, 16'd0);
    check_val("d2_sel2", sel2_f, 16'd2);

    // Load-use: LDR R7,[R1] ; ADD R8,R7,R7
    reset_dut();
    check_val("lu_cnt0", cnt_f, 16'd0);
    id_instr(4'd1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1);
    clk_edge(); to_negedge();
    id_instr(4'd7, 4'd7, 1'b1, 4'd8, 1'b1, 1'b0);
    #1 check_val("lu_stall1", stall_f, 16'd1);
    clk_edge();
    check_val("lu_bub_sel1", sel1_f, 16'd0);
    check_val("lu_bub_sel2", sel2_f, 16'd0);
    check_val("lu_cnt1", cnt_f, 16'd1);
    to_negedge();
    #1 check_val("lu_stall2", stall_f, 16'd0);
    clk_edge();
    check_val("lu_sel1", sel1_f, 16'd2);
    check_val("lu_sel2", sel2_f, 16'd2);
    check_val("lu_cnt_hold", cnt_f, 16'd1);

    // No forwarding: ADD R1 ; MOV R9,R1 -> two stall cycles
    reset_dut();
    id_instr(4'd2, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0);
    clk_edge(); to_negedge();
    id_instr(4'd1, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0);
    #1 check_val("nf_stall_c1", stall_n, 16'd1);
    clk_edge();
    check_val("nf_sel1_c1", sel1_n, 16'd0);
    to_negedge();
    #1 check_val("nf_stall_c2", stall_n, 16'd1);
    clk_edge(); to_negedge();
    #1 check_val("nf_stall_c3", stall_n, 16'd0);
    check_val("nf_cnt", cnt_n, 16'd2);
    clk_edge();
    check_val("nf_sel1_acc", sel1_n, 16'd0);
    check_val("nf_sel2_acc", sel2_n, 16'd0);

    // Branch over a load-use hazard: ADD R1 ; LDR R7,[R1] ; ADD R8,R7 + branch
    reset_dut();
    id_instr(4'd2, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
    clk_edge(); to_negedge();
    id_instr(4'd1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1);
    clk_edge();
    check_val("br_ldr_sel1", sel1_f, 16'd1);
    to_negedge();
    id_instr(4'd7, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0);
    branch_taken = 1'b1;
    #1 check_val("br_stall", stall_f, 16'd0);
    clk_edge();
    check_val("br_bub_sel1", sel1_f, 16'd0);
    to_negedge();
    id_instr(4'd7, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0);
    #1 check_val("br_after_stall", stall_f, 16'd0);
    check_val("br_cnt", cnt_f, 16'd0);
    clk_edge(); to_negedge();

    // Build a stall with nonzero sels and count, then reset mid-stall.
    id_instr(4'd2, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
    clk_edge(); to_negedge();
    id_instr(4'd1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1);
    clk_edge(); to_negedge();
    id_instr(4'd7, 4'd0, 1'b0, 4'd8, 1'b1, 1'b0);
    #1 check_val("rm_stall_a", stall_f, 16'd1);
    clk_edge(); to_negedge();
    id_instr(4'd7, 4'd0, 1'b0, 4'd9, 1'b1, 1'b1);
    clk_edge();
    check_val("rm_ldr9_sel1", sel1_f, 16'd2);
    to_negedge();
    id_instr(4'd9, 4'd0, 1'b0, 4'd10, 1'b1, 1'b0);
    #1 check_val("rm_stall_b", stall_f, 16'd1);
    check_val("rm_cnt_pre", cnt_f, 16'd1);
    rst = 1'b0;
    #1;
    check_val("rm_stall", stall_f, 16'd0);
    check_val("rm_sel1", sel1_f, 16'd0);
    check_val("rm_cnt", cnt_f, 16'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;

    // src2 gating: LDR R7 ; use R7 only as unread src2
    reset_dut();
    id_instr(4'd1, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1);
    clk_edge(); to_negedge();
    id_instr(4'd3, 4'd7, 1'b0, 4'd8, 1'b1, 1'b0);
    #1 check_val("gate_ld_stall", stall_f, 16'd0);
    clk_edge();
    check_val("gate_ld_sel2", sel2_f, 16'd0);
    to_negedge();
    id_instr(4'd3, 4'd8, 1'b0, 4'd9, 1'b1, 1'b0);
    clk_edge();
    check_val("gate_alu_sel2", sel2_f, 16'd0);
    check_val("gate_alu_sel1", sel1_f, 16'd0);

    // Saturation on the non-forwarding instance: preload 65534, then 3 stalls.
    reset_dut();
    force u_nf.stall_count_q = 16'd65534;
    #1;
    release u_nf.stall_count_q;
    #1;
    check_val("sat_preload", cnt_n, 16'd65534);
    // Same self-dependent instruction held in ID: accept, stall, stall, accept, stall.
    id_instr(4'd1, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
    clk_edge();
    check_val("sat_after_acc", cnt_n, 16'd65534);
    clk_edge();
    check_val("sat_first", cnt_n, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      clk_edge();
    end
    check_val("sat_final", cnt_n, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/forward_hazard_ctrl.md
FORWARD_HAZARD_CTRL -- requirements
Module: forward_hazard_ctrl

Interface
REQ-001 SHALL have parameter FORWARD_EN, default 1, meaning 1 = forwarding plus load-use stall, 0 = stall on every RAW hazard.
REQ-002 SHALL have ports clk in 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst in 1, asynchronous active-low reset.
REQ-004 SHALL have port id_valid in 1: the ID stage holds a real instruction.
REQ-005 SHALL have ports id_src1 in 4 and id_src2 in 4: source register numbers of the ID instruction.
REQ-006 SHALL have port id_src2_valid in 1: id_src2 is read (register-operand form, or store data).
REQ-007 SHALL have port id_dest in 4: the ID instruction's destination register.
REQ-008 SHALL have ports id_wb_en in 1 and id_mem_r_en in 1: the ID instruction writes back / is a load.
REQ-009 SHALL have port branch_taken in 1: the EXE instruction redirects the PC this cycle.
REQ-010 SHALL have port stall out 1 (combinational): freeze PC and IF/ID and insert a bubble into EXE.
REQ-011 SHALL have ports sel_src1 out 2 and sel_src2 out 2 (registered): forwarding selects for the instruction now in EXE; 00 = register file, 01 = MEM ALU result, 10 = WB value; 11 is never driven.
REQ-012 SHALL have port stall_count out 16 (registered): saturating count of stall cycles.

Function
REQ-013 SHALL hold three tracking slots, EXE, MEM and WB, each {valid, dest[3:0], wb_en, mem_r_en}.
REQ-014 SHALL, each cycle, shift MEM->WB and EXE->MEM unconditionally.
REQ-015 SHALL load EXE from the ID fields when id_valid=1, stall=0 and branch_taken=0; otherwise EXE SHALL load a bubble (valid=0).
REQ-016 SHALL define a slot as a producer only when valid=1 and wb_en=1; a match is producer.dest == the source, with id_src2 considered only when id_src2_valid=1.
REQ-017 SHALL, with FORWARD_EN=1, assert stall when id_valid=1 and the EXE slot is a load producer matching id_src1 or the gated id_src2.
REQ-018 SHALL, with FORWARD_EN=0, assert stall when id_valid=1 and the EXE or MEM slot is a producer matching any gated source.
REQ-019 SHALL force stall=0 when branch_taken=1, which has priority.
REQ-020 SHALL, with FORWARD_EN=1 and an instruction accepted into EXE, register sel_srcN = 01 on an EXE-slot match, else 10 on a MEM-slot match, else 00; the newer producer wins.
REQ-021 SHALL register sel_src1 = sel_src2 = 00 whenever a bubble is loaded into EXE, and always when FORWARD_EN=0.
REQ-022 SHALL treat a WB-slot match as no hazard, since the register file writes before the read.
REQ-023 SHALL increment stall_count on every cycle with stall=1, saturating at 16'hFFFF.
REQ-024 SHALL make stall a function of current slot state and ID inputs only, with no combinational path from any registered output.

Reset
REQ-025 SHALL, on rst=0, immediately clear all slot valid bits, sel_src1, sel_src2 and stall_count to 0, independent of clk.
REQ-026 SHALL, during reset, drive stall=0; a reset asserted mid-stall SHALL discard the pending hazard.
REQ-027 SHALL resume normal operation on the first rising clk edge after rst deasserts.

Structure
REQ-028 SHALL keep the sel encodings (SEL_RF=00, SEL_MEM=01, SEL_WB=10) and the slot record layout as constants in the shared pipeline package used by the EXE stage.
REQ-029 SHALL use one sub-module, hazard_match, instantiated per slot: combinational compare of one slot against src1/src2/src2_valid, returning match1 and match2.
REQ-030 SHALL need no other sub-modules; RTL size is roughly 150-250 lines.

Verification
REQ-031 SHALL cover ALU back-to-back (FORWARD_EN=1): ADD R1 then SUB R2,R1,R3 -> stall never 1; next edge sel_src1=01, sel_src2=00.
REQ-032 SHALL cover distance two: ADD R4, NOP, ORR R5,R6,R4 with id_src2_valid=1 -> sel_src2=10, stall=0.
REQ-033 SHALL cover load-use: LDR R7 then ADD R8,R7,R7 -> stall=1 for exactly one cycle, EXE bubble with sels 00, then ADD enters with sel_src1=sel_src2=10; stall_count goes 0->1.
REQ-034 SHALL cover FORWARD_EN=0: ADD R1 then MOV using R1 -> stall=1 for two cycles, sels stay 00, stall_count=2.
REQ-035 SHALL cover branch plus reset: branch_taken=1 while a load-use hazard exists -> stall=0 and bubble in EXE; then pull rst low mid-stall -> stall, sels and stall_count read 0 before the next clk edge.
REQ-036 SHALL cover saturation and gating: preload 65534 stalls, then 3 more -> stall_count=16'hFFFF; also a match on id_src2 with id_src2_valid=0 -> no stall and sel_src2=00.
